min_scan_reader: RTL and testbench
==================================

Name: min_scan_reader

Overview:
- Read-side companion to the data memory. Once the CPU program has written its array into data memory, this block reads the array back over a memory read port and finds the signed minimum and its index in hardware.
- Sits beside the CPU on the data-memory read port, muxed in by the bench or top level.
- Gives the bench an independent check of the CPU-computed min/min_idx results.

Parameters:
- BASE_ADR, 1000, byte address of element 0. Must be word-aligned (multiple of 4).
- COUNT, 20, number of 32-bit elements to scan. Must be ≥1; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request a scan; sampled only in IDLE or DONE
- mem_adr  output  32  byte address to data memory
- mem_read  output  1  read strobe to data memory
- mem_rdata  input  32  read data; combinational, valid in the same cycle as mem_adr
- busy  output  1  high while scanning
- done  output  1  level; high once results are valid, held until the next start or rst
- min  output  32  signed minimum found
- min_idx  output  32  zero-based index of the first occurrence of min

Behaviour:
- Reset: rst high at a clock edge forces state IDLE and clears all state. The reset value of every output is 0 (mem_adr, mem_read, busy, done, min, min_idx). Reset mid-scan aborts the scan with no partial results kept.
- States and transitions:
  - IDLE → SCAN on start. Counter i=0, done=0.
  - SCAN → SCAN while i<COUNT-1.
  - SCAN → DONE at the edge that samples element COUNT-1.
  - DONE → SCAN on start. done clears, i=0, min and min_idx keep old values until overwritten.
- SCAN outputs: mem_read=1, busy=1, mem_adr=BASE_ADR+4*i. Arithmetic is 32-bit and wraps modulo 2^32.
- Outside SCAN: mem_read=0, busy=0, mem_adr=0.
- Per SCAN edge:
  - If i==0: min←mem_rdata, min_idx←0, unconditionally.
  - Else if signed(mem_rdata) < signed(min): min←mem_rdata, min_idx←i.
  - Equal values do not update, so ties report the lowest index.
  - i increments each SCAN edge.
- Latency: start sampled at edge k gives SCAN from edge k through edge k+COUNT; done=1 after edge k+COUNT. Exactly COUNT read cycles; one element per cycle.
- start is ignored while in SCAN. A held start in DONE restarts every time DONE is reached; the bench pulses start for one cycle.
- start and rst high together: rst wins.
- min and min_idx are only meaningful while done=1. Intermediate values are visible during SCAN but not guaranteed to the consumer.

Test Plan:
- Reset then start, with memory [1000..1076] = 5,3,9,-2,7,... (20 words, -2 unique minimum at index 3) → mem_adr steps 1000,1004,...,1076 over 20 consecutive cycles with mem_read=1; done rises 20 cycles after the start edge; min=0xFFFFFFFE, min_idx=3.
- Ties: array 4,1,8,1,1,... (1 at indices 1, 3 and 4, no smaller value) → min=1, min_idx=1.
- Signed extremes: element 0 = 0x7FFFFFFF, element 19 = 0x80000000, others 0 → min=0x80000000, min_idx=19. Also minimum at index 0 (element 0 = -100, rest positive) → min_idx=0.
- start pulsed during SCAN at i=7 → ignored; mem_adr sequence continues unbroken; done still arrives 20 cycles after the original start.
- rst asserted at i=10 → next cycle all outputs 0, state IDLE. A subsequent start performs a full 20-element scan with correct results.
- After done, overwrite element 5 with -50 and pulse start → done drops the next cycle, then rises 20 cycles later with min=0xFFFFFFCE (-50), min_idx=5.

Source files
------------

// File: rtl/min_scan_reader.sv
// Reads COUNT consecutive words from data memory starting at BASE_ADR and
// reports the signed minimum and the index of its first occurrence.
module min_scan_reader #(
  parameter logic [31:0] BASE_ADR = 32'd1000,
  parameter int unsigned COUNT    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] mem_adr,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] min,
  output logic [31:0] min_idx
);

  if (COUNT < 1) begin : g_bad_count
    $fatal(1, "min_scan_reader: COUNT must be at least 1");
  end
  if (BASE_ADR[1:0] != 2'b00) begin : g_bad_base
    $fatal(1, "min_scan_reader: BASE_ADR must be word-aligned");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] LAST_IDX = 32'(COUNT - 1);

  state_t      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] min_q, min_d;
  logic [31:0] min_idx_q, min_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      min_q     <= '0;
      min_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    min_d     = min_q;
    min_idx_d = min_idx_q;
    mem_read  = 1'b0;
    busy      = 1'b0;
    mem_adr   = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        mem_read = 1'b1;
        busy     = 1'b1;
        mem_adr  = BASE_ADR + {idx_q[29:0], 2'b00};
        // Strict less-than keeps the earliest index on ties.
        if (idx_q == '0 || $signed(mem_rdata) < $signed(min_q)) begin
          min_d     = mem_rdata;
          min_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done    = (state_q == DONE);
  assign min     = min_q;
  assign min_idx = min_idx_q;

endmodule

// File: tb/tb_min_scan_reader.sv
// Directed bench for min_scan_reader: a 20-word memory model answers the read
// port combinationally; address sequence, handshake and results are checked.
module tb_min_scan_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] mem_adr;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] min;
  logic [31:0] min_idx;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] mem [0:19];
  logic [31:0] off;

  min_scan_reader #(
    .BASE_ADR(32'd1000),
    .COUNT   (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_adr  (mem_adr),
    .mem_read (mem_read),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done),
    .min      (min),
    .min_idx  (min_idx)
  );

  always #5 clk = ~clk;

  assign off = mem_adr - 32'd1000;
  always_comb begin
    mem_rdata = 32'hDEAD_BEEF;
    if (off[1:0] == 2'b00 && off < 32'd80) mem_rdata = mem[off[6:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_a();
    mem[0] = 32'd5; mem[1] = 32'd3; mem[2] = 32'd9; mem[3] = 32'hFFFF_FFFE; mem[4] = 32'd7;
    for (int i = 5; i < 20; i++) mem[i] = 32'(10 + i);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Run cycles 0..19 of a scan already started; optionally pulse start at one cycle.
  task automatic run_scan(input string tag, input logic [31:0] emin, input logic [31:0] eidx,
                          input int pulse_at);
    for (int c = 0; c < 20; c++) begin
      chk({tag, "_adr"}, mem_adr, 32'(1000 + 4 * c));
      chk({tag, "_rd_busy_done"}, {29'd0, mem_read, busy, done}, 32'b110);
      start = (c == pulse_at);
      tick();
    end
    start = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_min"}, min, emin);
    chk({tag, "_idx"}, min_idx, eidx);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) mem[i] = '0;
    tick();
    tick();
    // Reset state, with start also high to show reset wins.
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    chk("rst_adr", mem_adr, 32'd0);
    chk("rst_read", {31'd0, mem_read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_min", min, 32'd0);
    chk("rst_idx", min_idx, 32'd0);
    tick();
    chk("idle_hold", {30'd0, busy, done}, 32'd0);

    // Unique minimum -2 at index 3.
    fill_a();
    do_start();
    run_scan("uniq", 32'hFFFF_FFFE, 32'd3, -1);
    tick();
    chk("done_held", {31'd0, done}, 32'd1);

    // Ties at 1: first occurrence wins.
    mem[0] = 32'd4; mem[1] = 32'd1; mem[2] = 32'd8; mem[3] = 32'd1; mem[4] = 32'd1;
    for (int i = 5; i < 20; i++) mem[i] = 32'd6;
    do_start();
    run_scan("ties", 32'd1, 32'd1, -1);

    // Signed extremes: most negative value at the last index.
    for (int i = 0; i < 20; i++) mem[i] = '0;
    mem[0]  = 32'h7FFF_FFFF;
    mem[19] = 32'h8000_0000;
    do_start();
    run_scan("ext", 32'h8000_0000, 32'd19, -1);

    // Minimum at index 0.
    mem[0] = 32'hFFFF_FF9C;
    for (int i = 1; i < 20; i++) mem[i] = 32'(i + 1);
    do_start();
    run_scan("first", 32'hFFFF_FF9C, 32'd0, -1);

    // start pulsed mid-scan at i=7 must be ignored.
    fill_a();
    do_start();
    run_scan("midstart", 32'hFFFF_FFFE, 32'd3, 7);
    tick();
    chk("midstart_no_restart", {30'd0, busy, done}, 32'b01);

    // Reset at i=10 aborts the scan and clears everything.
    do_start();
    for (int c = 0; c < 10; c++) tick();
    chk("pre_rst_adr", mem_adr, 32'd1040);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_adr", mem_adr, 32'd0);
    chk("abort_flags", {29'd0, mem_read, busy, done}, 32'd0);
    chk("abort_min", min, 32'd0);
    chk("abort_idx", min_idx, 32'd0);
    tick();
    chk("abort_idle", {30'd0, busy, done}, 32'd0);
    do_start();
    run_scan("after_rst", 32'hFFFF_FFFE, 32'd3, -1);

    // Rescan from DONE after overwriting element 5; old results held at first.
    mem[5] = 32'hFFFF_FFCE;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rescan_min_held", min, 32'hFFFF_FFFE);
    run_scan("rescan", 32'hFFFF_FFCE, 32'd5, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
